// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC-update sequencer.
//   - FSM state encoding
//   - pc_src, alu_pc_op and exc_cause encodings
//   - opcode/funct constants and the legal-opcode set
//   - dispatch classes produced by pc_seq_decode
//   - packed bundle of the registered control outputs
package pc_seq_pkg;

   typedef enum logic [3:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_JUMP,
      S_JR,
      S_RTE,
      S_BRANCH,
      S_EXEC,
      S_EXC_SAVE,
      S_EXC_VEC
   } state_t;

   typedef enum logic [1:0] {
      PC_SRC_ALU    = 2'b00,  // ALU result
      PC_SRC_JUMP   = 2'b01,  // {PC[31:28], IR[25:0], 2'b00}
      PC_SRC_ALUOUT = 2'b10,  // ALUOut (latched branch target)
      PC_SRC_EPC    = 2'b11   // EPC
   } pc_src_t;

   typedef enum logic [2:0] {
      ALU_IDLE   = 3'b000,
      ALU_INC    = 3'b001,  // PC + 4
      ALU_BTGT   = 3'b010,  // PC + (sext(imm) << 2)
      ALU_DEC    = 3'b011,  // PC - 4
      ALU_PASS   = 3'b100,  // pass rs
      ALU_CMP    = 3'b101,  // rs - rt
      ALU_EXCVEC = 3'b110   // 0xFD + exc_cause
   } alu_pc_op_t;

   typedef enum logic [1:0] {
      CAUSE_ILLEGAL  = 2'b00,
      CAUSE_OVERFLOW = 2'b01,
      CAUSE_TIMEOUT  = 2'b10
   } exc_cause_t;

   typedef enum logic [2:0] {
      CLS_JUMP,
      CLS_JR,
      CLS_RTE,
      CLS_BRANCH,
      CLS_EXEC,
      CLS_ILLEGAL
   } disp_class_t;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLE    = 6'h06;
   localparam logic [5:0] OP_BGT    = 6'h07;
   localparam logic [5:0] FUNCT_JR  = 6'h08;
   localparam logic [5:0] FUNCT_RTE = 6'h13;

   // Registered control outputs (pc_write here excludes the Mealy branch term).
   typedef struct packed {
      logic       exec_start;
      logic       ir_write;
      logic       mem_read;
      logic       pc_write;
      pc_src_t    pc_src;
      alu_pc_op_t alu_pc_op;
      logic       epc_write;
   } ctl_t;

   // Opcodes handed to the main execute control.
   function automatic logic is_legal_op(input logic [5:0] op);
      case (op)
         6'h00, 6'h01, 6'h08, 6'h09, 6'h0F,
         6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pc_seq_decode.sv
// pc_seq_decode: combinational opcode/funct classifier for the DECODE dispatch.
//   op     in  6  IR[31:26]
//   funct  in  6  IR[5:0]
//   cls    out    dispatch class (jump, jr, rte, branch, exec, illegal)
//   legal  out 1  instruction is recognised
module pc_seq_decode
   import pc_seq_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   output disp_class_t cls,
   output logic        legal
);

   // Control-flow forms are checked before the generic legal-opcode set, so
   // R-type jr/rte win over the plain R-type execute path.
   // NOTE: cls gets a default before any branch so no latch is inferred.
   always_comb begin
      cls = CLS_ILLEGAL;
      if (op == OP_J || op == OP_JAL)
         cls = CLS_JUMP;
      else if (op == OP_RTYPE && funct == FUNCT_JR)
         cls = CLS_JR;
      else if (op == OP_RTYPE && funct == FUNCT_RTE)
         cls = CLS_RTE;
      else if (op == OP_BEQ || op == OP_BNE || op == OP_BLE || op == OP_BGT)
         cls = CLS_BRANCH;
      else if (is_legal_op(op))
         cls = CLS_EXEC;
   end

   assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle PC-update controller for the MIPS-subset core.
// Sequences fetch, jump, jr, branch, rte and exception entry, and hands
// ordinary instructions to the execute control via exec_start/exec_done.
//   clk, reset          clock, synchronous active-high reset
//   op, funct           IR[31:26], IR[5:0]
//   zero, gt            ALU flags, used combinationally in BRANCH
//   overflow, exec_done execute completion (overflow qualified by exec_done)
//   exec_start          one-cycle execute start pulse
//   ir_write, mem_read  instruction fetch controls
//   pc_write, pc_src    PC load enable and source mux select
//   alu_pc_op           PC-related ALU operation
//   epc_write           EPC load enable
//   exc_cause           cause of the most recent exception
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int MEM_WAIT     = 1,
   parameter int EXEC_TIMEOUT = 15,
   parameter int CNT_W        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       gt,
   input  logic       overflow,
   input  logic       exec_done,
   output logic       exec_start,
   output logic       ir_write,
   output logic       mem_read,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic [2:0] alu_pc_op,
   output logic       epc_write,
   output logic [1:0] exc_cause
);

   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(MEM_WAIT - 1);
   localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_TIMEOUT - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   exc_cause_t       cause_q, cause_nx;
   ctl_t             ctl_q, ctl_nx;
   disp_class_t      cls;
   logic             legal;
   logic             branch_taken;

   pc_seq_decode u_decode (
      .op    (op),
      .funct (funct),
      .cls   (cls),
      .legal (legal)
   );

   // Next state, counter and cause. The counter restarts on every state
   // change, so FETCH and EXEC both see it begin at zero.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + CNT_W'(1);
      cause_nx = cause_q;
      case (state)
         S_RESET: state_nx = S_FETCH;
         S_FETCH: if (cnt == FETCH_LAST) state_nx = S_DECODE;
         S_DECODE: begin
            case (cls)
               CLS_JUMP:   state_nx = S_JUMP;
               CLS_JR:     state_nx = S_JR;
               CLS_RTE:    state_nx = S_RTE;
               CLS_BRANCH: state_nx = S_BRANCH;
               CLS_EXEC:   state_nx = S_EXEC;
               default: begin
                  state_nx = S_EXC_SAVE;
                  cause_nx = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_JUMP, S_JR, S_RTE, S_BRANCH, S_EXC_VEC: state_nx = S_FETCH;
         S_EXEC: begin
            if (exec_done && overflow) begin
               state_nx = S_EXC_SAVE;
               cause_nx = CAUSE_OVERFLOW;
            end else if (exec_done) begin
               state_nx = S_FETCH;
            end else if (cnt == EXEC_LAST) begin
               state_nx = S_EXC_SAVE;
               cause_nx = CAUSE_TIMEOUT;
            end
         end
         S_EXC_SAVE: state_nx = S_EXC_VEC;
         default:    state_nx = S_RESET;
      endcase
      if (state_nx != state)
         cnt_nx = '0;
   end

   // Outputs are decoded from the upcoming state and registered, so each
   // output is a clean Moore function of the state it is observed in.
   always_comb begin
      ctl_nx = '0;
      case (state_nx)
         S_FETCH: begin
            ctl_nx.mem_read = 1'b1;
            if (cnt_nx == FETCH_LAST) begin
               ctl_nx.ir_write  = 1'b1;
               ctl_nx.pc_write  = 1'b1;
               ctl_nx.pc_src    = PC_SRC_ALU;
               ctl_nx.alu_pc_op = ALU_INC;
            end
         end
         S_DECODE: ctl_nx.alu_pc_op = ALU_BTGT;
         S_JUMP: begin
            ctl_nx.pc_write = 1'b1;
            ctl_nx.pc_src   = PC_SRC_JUMP;
         end
         S_JR: begin
            ctl_nx.pc_write  = 1'b1;
            ctl_nx.pc_src    = PC_SRC_ALU;
            ctl_nx.alu_pc_op = ALU_PASS;
         end
         S_RTE: begin
            ctl_nx.pc_write = 1'b1;
            ctl_nx.pc_src   = PC_SRC_EPC;
         end
         S_BRANCH: begin
            ctl_nx.pc_src    = PC_SRC_ALUOUT;
            ctl_nx.alu_pc_op = ALU_CMP;
         end
         // EXEC is only entered from DECODE, so the pulse lasts one cycle.
         S_EXEC: ctl_nx.exec_start = (state != S_EXEC);
         S_EXC_SAVE: begin
            ctl_nx.alu_pc_op = ALU_DEC;
            ctl_nx.epc_write = 1'b1;
         end
         S_EXC_VEC: begin
            ctl_nx.pc_write  = 1'b1;
            ctl_nx.pc_src    = PC_SRC_ALU;
            ctl_nx.alu_pc_op = ALU_EXCVEC;
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_RESET;
         cnt     <= '0;
         cause_q <= CAUSE_ILLEGAL;
         ctl_q   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         cause_q <= cause_nx;
         ctl_q   <= ctl_nx;
      end
   end

   // Branch condition is taken straight from the live ALU flags.
   always_comb begin
      case (op)
         OP_BEQ:  branch_taken = zero;
         OP_BNE:  branch_taken = !zero;
         OP_BLE:  branch_taken = !gt;
         default: branch_taken = gt;
      endcase
   end

   assign exec_start = ctl_q.exec_start;
   assign ir_write   = ctl_q.ir_write;
   assign mem_read   = ctl_q.mem_read;
   assign pc_write   = ctl_q.pc_write | ((state == S_BRANCH) & branch_taken);
   assign pc_src     = ctl_q.pc_src;
   assign alu_pc_op  = ctl_q.alu_pc_op;
   assign epc_write  = ctl_q.epc_write;
   assign exc_cause  = cause_q;

endmodule
